// File: rtl/phase_sequencer_pkg.sv
// Shared definitions for the phase sequencer: mode encoding and one-hot phase helpers.
package phase_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_RUN    = 2'd1,
        MODE_STEP_P = 2'd2,
        MODE_STEP_I = 2'd3
    } mode_e;

    localparam int unsigned PHASE_FETCH = 0;
    // Widest phase vector the helper can describe; callers cast down to PHASES bits.
    localparam int unsigned PHASE_MAX   = 64;

    function automatic logic [PHASE_MAX-1:0] phase_onehot(input int unsigned phases,
                                                          input int unsigned k);
        return PHASE_MAX'(1) << (k % phases);
    endfunction

endpackage

// File: rtl/phase_sequencer_edge_detect.sv
// Rising-edge detector: registered previous level, pulse_c = level & ~previous.
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse_c
);

    logic prev;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign pulse_c = level & ~prev;

endmodule

// File: rtl/phase_sequencer.sv
// One-hot phase generator with run/step modes, stall handshake, halt, stall timeout
// and a completed-instruction counter.
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter int unsigned PHASES   = 4,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              step_phase,
    input  logic              step_inst,
    input  logic              stall,
    input  logic              halt,
    output logic [PHASES-1:0] cstate,
    output logic              running,
    output logic              inst_done,
    output logic              timeout,
    output logic [CNT_W-1:0]  icount
);

    localparam int unsigned SC_W = $clog2(WAIT_MAX + 1);
    localparam logic [PHASES-1:0] FETCH_ONEHOT = PHASES'(phase_onehot(PHASES, PHASE_FETCH));
    localparam logic [PHASES-1:0] LAST_ONEHOT  = PHASES'(phase_onehot(PHASES, PHASES - 1));

    mode_e             mode_q, mode_d;
    logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic              run_block_q, run_block_d;
    logic [PHASES-1:0] cstate_d;
    logic              running_d, inst_done_d, timeout_d;
    logic [CNT_W-1:0]  icount_d;
    logic              sp_edge_c, si_edge_c;

    edge_detect u_step_phase_edge (
        .clock   (clock),
        .reset   (reset),
        .level   (step_phase),
        .pulse_c (sp_edge_c)
    );

    edge_detect u_step_inst_edge (
        .clock   (clock),
        .reset   (reset),
        .level   (step_inst),
        .pulse_c (si_edge_c)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mode_q      <= MODE_IDLE;
            stall_cnt_q <= '0;
            run_block_q <= 1'b0;
            cstate      <= FETCH_ONEHOT;
            running     <= 1'b0;
            inst_done   <= 1'b0;
            timeout     <= 1'b0;
            icount      <= '0;
        end else begin
            mode_q      <= mode_d;
            stall_cnt_q <= stall_cnt_d;
            run_block_q <= run_block_d;
            cstate      <= cstate_d;
            running     <= running_d;
            inst_done   <= inst_done_d;
            timeout     <= timeout_d;
            icount      <= icount_d;
        end
    end

    // Mode transitions, phase rotation, stall accounting and completion bookkeeping.
    always_comb begin
        mode_d      = mode_q;
        stall_cnt_d = stall_cnt_q;
        run_block_d = run_block_q;
        cstate_d    = cstate;
        inst_done_d = 1'b0;
        timeout_d   = timeout;
        icount_d    = icount;

        // After a halt, run must be seen low once before RUN can be re-entered.
        if (!run) begin
            run_block_d = 1'b0;
        end

        case (mode_q)
            MODE_IDLE: begin
                stall_cnt_d = '0;
                if (!timeout) begin
                    if (run && !run_block_q) begin
                        mode_d = MODE_RUN;
                    end else if (si_edge_c) begin
                        mode_d = MODE_STEP_I;
                    end else if (sp_edge_c) begin
                        mode_d = MODE_STEP_P;
                    end
                end
            end
            default: begin
                if (stall) begin
                    if (stall_cnt_q == SC_W'(WAIT_MAX)) begin
                        timeout_d = 1'b1;
                        mode_d    = MODE_IDLE;
                    end else begin
                        stall_cnt_d = stall_cnt_q + SC_W'(1);
                    end
                end else begin
                    stall_cnt_d = '0;
                    cstate_d    = {cstate[PHASES-2:0], cstate[PHASES-1]};
                    if (cstate == LAST_ONEHOT) begin
                        icount_d    = icount + CNT_W'(1);
                        inst_done_d = 1'b1;
                        if (halt) begin
                            mode_d      = MODE_IDLE;
                            run_block_d = 1'b1;
                        end else if (!(mode_q == MODE_RUN && run)) begin
                            mode_d = MODE_IDLE;
                        end
                    end else if (mode_q == MODE_STEP_P) begin
                        mode_d = MODE_IDLE;
                    end
                end
            end
        endcase

        running_d = (mode_d != MODE_IDLE);
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: directed scenarios plus randomized stimulus
// compared every cycle against a phase-index reference model.
module tb_phase_sequencer;

    localparam int unsigned PHASES   = 4;
    localparam int unsigned WAIT_MAX = 15;
    localparam int unsigned CNT_W    = 8;
    localparam int M_IDLE = 0, M_RUN = 1, M_STEPP = 2, M_STEPI = 3;

    logic              clock;
    logic              reset;
    logic              run, step_phase, step_inst, stall, halt;
    logic [PHASES-1:0] cstate;
    logic              running, inst_done, timeout;
    logic [CNT_W-1:0]  icount;

    int n_checks = 0;
    int n_fail   = 0;
    int burst    = 0;

    // Reference model state
    int m_mode, m_phase, m_wait, m_icount;
    bit m_done, m_timeout, m_block, m_prev_sp, m_prev_si;

    phase_sequencer #(
        .PHASES   (PHASES),
        .WAIT_MAX (WAIT_MAX),
        .CNT_W    (CNT_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .step_phase (step_phase),
        .step_inst  (step_inst),
        .stall      (stall),
        .halt       (halt),
        .cstate     (cstate),
        .running    (running),
        .inst_done  (inst_done),
        .timeout    (timeout),
        .icount     (icount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_phase = 0; m_wait = 0; m_icount = 0;
        m_done = 0; m_timeout = 0; m_block = 0; m_prev_sp = 0; m_prev_si = 0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_update();
        bit e_sp, e_si, set_block, last;
        e_sp = step_phase && !m_prev_sp;
        e_si = step_inst && !m_prev_si;
        m_prev_sp = step_phase;
        m_prev_si = step_inst;
        m_done = 0;
        set_block = 0;
        if (m_mode == M_IDLE) begin
            m_wait = 0;
            if (!m_timeout) begin
                if (run && !m_block) m_mode = M_RUN;
                else if (e_si)       m_mode = M_STEPI;
                else if (e_sp)       m_mode = M_STEPP;
            end
        end else if (stall) begin
            if (m_wait + 1 > int'(WAIT_MAX)) begin
                m_timeout = 1;
                m_mode = M_IDLE;
            end else begin
                m_wait++;
            end
        end else begin
            m_wait = 0;
            last = (m_phase == int'(PHASES) - 1);
            m_phase = (m_phase + 1) % int'(PHASES);
            if (last) begin
                m_icount = (m_icount + 1) % (1 << CNT_W);
                m_done = 1;
                if (halt) begin
                    m_mode = M_IDLE;
                    set_block = 1;
                end else if (!(m_mode == M_RUN && run)) begin
                    m_mode = M_IDLE;
                end
            end else if (m_mode == M_STEPP) begin
                m_mode = M_IDLE;
            end
        end
        if (set_block) m_block = 1;
        else if (!run) m_block = 0;
    endtask

    task automatic check_all();
        check("cstate",    64'(cstate),    64'(1) << m_phase);
        check("running",   64'(running),   64'(m_mode != M_IDLE));
        check("inst_done", 64'(inst_done), 64'(m_done));
        check("timeout",   64'(timeout),   64'(m_timeout));
        check("icount",    64'(icount),    64'(m_icount));
    endtask

    task automatic tick();
        model_update();
        @(posedge clock);
        #1;
        check_all();
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clock);
        #1;
        check_all();
        reset = 1'b1;
    endtask

    task automatic idle_inputs();
        run = 0; step_phase = 0; step_inst = 0; stall = 0; halt = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1;
        do_reset();

        // Free run: 1,2,4,8,1 and icount = 3 after 12 advances
        run = 1;
        tick();
        check("s1_running", 64'(running), 64'(1));
        for (int i = 0; i < 12; i++) begin
            tick();
            check("s1_cstate", 64'(cstate), 64'(1) << ((i + 1) % 4));
            check("s1_done", 64'(inst_done), 64'(((i + 1) % 4) == 0));
        end
        check("s1_icount", 64'(icount), 64'(3));

        // Drop run during phase 2: instruction finishes, then stop
        tick();
        check("s4_cstate2", 64'(cstate), 64'(2));
        run = 0;
        tick(); tick(); tick();
        check("s4_cstate", 64'(cstate), 64'(1));
        check("s4_icount", 64'(icount), 64'(4));
        check("s4_running", 64'(running), 64'(0));
        tick();
        check("s4_stays", 64'(cstate), 64'(1));

        // Step phase twice; an edge during a stalled step is ignored
        do_reset();
        step_phase = 1; tick();
        step_phase = 0; tick();
        check("s2_cstate1", 64'(cstate), 64'(2));
        step_phase = 1; stall = 1; tick();
        step_phase = 0; tick();
        step_phase = 1; tick();
        stall = 0; tick();
        step_phase = 0; tick(); tick();
        check("s2_cstate", 64'(cstate), 64'(4));
        check("s2_running", 64'(running), 64'(0));
        check("s2_icount", 64'(icount), 64'(0));

        // Step instruction with a 3-cycle stall in phase 2: 7 cycles
        do_reset();
        step_inst = 1; tick();
        step_inst = 0;
        tick();
        stall = 1; tick(); tick(); tick();
        stall = 0; tick(); tick();
        check("s3_notdone", 64'(icount), 64'(0));
        tick();
        check("s3_icount", 64'(icount), 64'(1));
        check("s3_done", 64'(inst_done), 64'(1));
        check("s3_running", 64'(running), 64'(0));

        // Halt at phase 8 with run held; resume after run low for one cycle
        do_reset();
        run = 1;
        tick(); tick(); tick(); tick();
        check("s5_phase8", 64'(cstate), 64'(8));
        halt = 1; tick();
        halt = 0;
        check("s5_running", 64'(running), 64'(0));
        check("s5_icount", 64'(icount), 64'(1));
        tick(); tick();
        check("s5_held", 64'(running), 64'(0));
        run = 0; tick();
        run = 1; tick();
        check("s5_resume", 64'(running), 64'(1));
        tick();
        check("s5_adv", 64'(cstate), 64'(2));

        // Reset mid-instruction discards the partial instruction
        tick();
        do_reset();
        check("rst_cstate", 64'(cstate), 64'(1));
        check("rst_icount", 64'(icount), 64'(0));

        // Stall timeout: 16 stalled cycles with WAIT_MAX = 15
        run = 1; tick(); tick();
        stall = 1;
        for (int i = 0; i < 15; i++) tick();
        check("s6_pre", 64'(timeout), 64'(0));
        tick();
        check("s6_timeout", 64'(timeout), 64'(1));
        check("s6_running", 64'(running), 64'(0));
        check("s6_cstate", 64'(cstate), 64'(2));
        stall = 0; tick(); tick();
        check("s6_ignored", 64'(running), 64'(0));
        run = 0; step_inst = 1; tick();
        step_inst = 0; step_phase = 1; tick();
        check("s6_ignored2", 64'(running), 64'(0));
        do_reset();
        check("s6_cleared", 64'(timeout), 64'(0));

        // Randomized traffic against the model
        idle_inputs();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) run = ~run;
            if (burst == 0 && $urandom_range(0, 799) == 0) burst = 20;
            if (burst > 0) begin
                stall = 1;
                burst--;
            end else begin
                stall = ($urandom_range(0, 4) == 0);
            end
            halt       = ($urandom_range(0, 9) == 0);
            step_phase = ($urandom_range(0, 2) == 0);
            step_inst  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 599) == 0) do_reset();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised, sequential successor to the combinational controller's phase input. It generates the one-hot `cstate` that drives the controller and datapath, and adds several things the fixed 4-phase generator lacks: a configurable phase count, run/step-phase/step-instruction modes, stall handshaking from memory, halt-at-instruction-boundary, a stall timeout, and an instruction counter. It sits between the front-panel/debug inputs and the controller.

## Interface
- `PHASES`, default 4: number of phases and width of one-hot `cstate`; legal range ≥ 2.
- `WAIT_MAX`, default 15: maximum consecutive stalled cycles tolerated in one phase; legal range ≥ 1.
- `CNT_W`, default 32: width of the instruction counter.

Ports (clock and reset first):
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; high = free-running execution.
- `step_phase`  in  1  rising edge requests a single phase advance.
- `step_inst`  in  1  rising edge requests execution up to the next instruction boundary.
- `stall`  in  1  high = hold the current phase (memory or datapath not ready).
- `halt`  in  1  instruction requests stop; sampled only when the last phase completes.
- `cstate`  out  PHASES  one-hot phase; bit 0 = fetch.
- `running`  out  1  high while the sequencer is advancing phases in any mode.
- `inst_done`  out  1  one-cycle pulse when an instruction completes.
- `timeout`  out  1  sticky error flag; set when a stall limit is exceeded.
- `icount`  out  CNT_W  number of completed instructions, wrapping.

## Operation
- Mode FSM has four states:
  - IDLE: waiting for a request.
  - RUN: free-running.
  - STEP_P: single phase.
  - STEP_I: single instruction.
- Step requests use internal edge detection. Each of `step_phase` and `step_inst` has a registered previous value that resets to 0. An edge is current = 1 and previous = 0.
- IDLE transitions, priority high to low:
  - `run` = 1 → RUN.
  - `step_inst` edge → STEP_I.
  - `step_phase` edge → STEP_P.
  - Otherwise stay in IDLE.
- A phase "advances" on a cycle in a non-IDLE state with `stall` = 0. On an advance, `cstate` rotates left by one; from bit PHASES-1 it wraps to bit 0.
- "Completion" is an advance out of phase PHASES-1.
- RUN:
  - Advances every unstalled cycle.
  - If `run` falls, the current instruction finishes and the FSM returns to IDLE at completion. It never stops mid-instruction.
- STEP_P: performs exactly one advance (waiting out any stall), then returns to IDLE.
- STEP_I: advances until completion, then returns to IDLE.
- Halt: if `halt` = 1 at a completion in any mode, the FSM goes to IDLE. RUN is not re-entered until `run` has been seen low for at least one cycle.
- Step edges arriving outside IDLE are ignored. They are not queued.
- Stall counter, width $clog2(WAIT_MAX+1):
  - Increments on each stalled cycle in a non-IDLE state.
  - Clears on any advance.
  - When it would exceed WAIT_MAX: set `timeout`, force the FSM to IDLE, and leave `cstate` unchanged.
  - While `timeout` = 1, all requests are ignored until reset.
- `icount` increments by 1 on every completion and wraps modulo 2^CNT_W.

## Timing
- Reset values: `cstate` = 1 (fetch), `running` = 0, `inst_done` = 0, `timeout` = 0, `icount` = 0, FSM = IDLE, stall counter = 0, edge registers = 0.
- All outputs are registered. There is no combinational path from input to output.
- Start latency: a request sampled at edge N makes the FSM non-IDLE after edge N. The first advance happens at edge N+1 if `stall` = 0.
- `running` is 1 exactly in the cycles where the FSM is non-IDLE.
- `inst_done` is high for the single cycle in which `cstate` has just returned to bit 0 because of a completion. `icount` updates on the same edge.
- An unstalled instruction in RUN takes exactly PHASES cycles. Each stalled cycle adds one cycle.
- If `stall` and `halt` are asserted together in the last phase, `halt` is not sampled until the stall releases.
- Asserting `reset` mid-instruction returns everything to reset values immediately, asynchronously. The partial instruction is not counted.

## Structure
- A shared package holds:
  - The mode state encoding (IDLE, RUN, STEP_P, STEP_I).
  - A `PHASE_FETCH` constant and a helper function returning the one-hot phase k for a given PHASES.
- One sub-module, `edge_detect`: a registered rising-edge pulse generator with asynchronous active-low reset. It is instantiated twice, once each for `step_phase` and `step_inst`.

## Test plan
- Reset then `run` = 1 with PHASES = 4 and `stall` = 0: `cstate` goes 1, 2, 4, 8, 1. `inst_done` pulses every 4th cycle, and `icount` = 3 after 12 advances.
- `step_phase` edge ×2 from reset: `cstate` ends at 4, `running` = 0 afterwards, and `icount` = 0. A second edge issued while stepping is ignored.
- `step_inst` edge with `stall` high for 3 cycles in phase 2: the instruction completes in 7 cycles, `icount` = 1, and the FSM returns to IDLE.
- In RUN, drop `run` during phase 2: phases 4 and 8 still occur, the sequencer stops with `cstate` = 1, `icount` increments by exactly 1, and then `running` = 0.
- `halt` = 1 at phase 8 with `run` held high: the sequencer stops after the completion. Lowering `run` for 1 cycle and raising it again resumes execution.
- With WAIT_MAX = 15, hold `stall` for 16 cycles: `timeout` = 1, `running` = 0, `cstate` is unchanged, and later `run` is ignored. Asserting `reset` clears everything.
